// File: rtl/rvv_issue_frontend_pkg.sv
// -----------------------------------------------------------------------------
// rvv_issue_frontend_pkg
// Shared types and constants for the vector issue front-end: scalar width,
// instruction ID type, the vl/vtype context snapshot and the queued entry
// layout, plus default depth and completion-source count.
// -----------------------------------------------------------------------------
package rvv_issue_frontend_pkg;

    localparam int XLEN = 32;

    typedef logic [2:0] insn_id_t;

    // Every ID can be outstanding at most once, so this bounds in-flight work.
    localparam int InsnIDNum = 2 ** $bits(insn_id_t);

    typedef struct packed {
        logic [15:0] vl;
        logic [7:0]  vtype;
    } vec_context_t;

    typedef struct packed {
        logic [31:0]     insn;
        insn_id_t        id;
        logic [XLEN-1:0] scalar;
        vec_context_t    ctx;
    } frontend_entry_t;

    localparam int FrontendDepth = 4;
    localparam int NrDoneSrc     = 3;

endpackage

// File: rtl/rvv_issue_frontend_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rvv_issue_frontend_rr_arbiter
// Round-robin arbiter. Grants the first requester at or after the rotating
// pointer (wrapping). When advance_i is high and a grant is issued, the
// pointer moves to the slot after the winner, so a requester that keeps its
// request asserted is served within NrReq cycles.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         per-requester request
//   advance_i     allow the pointer to rotate past this cycle's winner
//   gnt_o         one-hot grant, combinational
// -----------------------------------------------------------------------------
module rvv_issue_frontend_rr_arbiter
    import rvv_issue_frontend_pkg::*;
#(
    parameter int NrReq = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] req_i,
    input  logic             advance_i,
    output logic [NrReq-1:0] gnt_o
);

    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] gidx, idx;
    logic            found;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NrReq; i++) begin
            idx = PtrW'((int'(ptr_q) + i) % NrReq);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            gnt_o[gidx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (gidx == PtrW'(NrReq - 1)) ? '0 : gidx + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rvv_issue_frontend.sv
// -----------------------------------------------------------------------------
// rvv_issue_frontend
// Front-end between the scalar core issue/commit interface and the vector
// decoder. Buffers instruction + scalar operand + vl/vtype context in a
// QueueDepth-entry FIFO with a fall-through head, limits queued plus
// dispatched-not-done work to MaxInflight, drops queued entries on flush, and
// merges NrDoneSrc completion sources into one registered done stream.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   valid_i/ready_o, insn_i,
//   insn_id_i, scalar_reg_i,
//   vec_context_i                     instruction offer from the scalar core
//   flush_i                           discard all queued entries
//   dec_valid_o/dec_ready_i, dec_*_o  head entry toward the decoder
//   src_done_i, src_done_id_i,
//   src_illegal_i, src_gnt_o          completion sources and their grants
//   done_o, done_insn_id_o,
//   illegal_insn_o                    registered completion to scalar core
//   inflight_o                        dispatched-not-done count
// IdWidth must equal $bits(insn_id_t), since queued IDs live in that field.
// -----------------------------------------------------------------------------
module rvv_issue_frontend
    import rvv_issue_frontend_pkg::*;
#(
    parameter int QueueDepth  = FrontendDepth,
    parameter int NrDoneSrc   = rvv_issue_frontend_pkg::NrDoneSrc,
    parameter int MaxInflight = InsnIDNum,
    parameter int IdWidth     = $bits(insn_id_t)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [31:0]                        insn_i,
    input  logic [IdWidth-1:0]                 insn_id_i,
    input  logic [XLEN-1:0]                    scalar_reg_i,
    input  logic [$bits(vec_context_t)-1:0]    vec_context_i,
    input  logic                               flush_i,
    output logic                               dec_valid_o,
    input  logic                               dec_ready_i,
    output logic [31:0]                        dec_insn_o,
    output logic [IdWidth-1:0]                 dec_id_o,
    output logic [XLEN-1:0]                    dec_scalar_o,
    output logic [$bits(vec_context_t)-1:0]    dec_ctx_o,
    input  logic [NrDoneSrc-1:0]               src_done_i,
    input  logic [NrDoneSrc*IdWidth-1:0]       src_done_id_i,
    input  logic [NrDoneSrc-1:0]               src_illegal_i,
    output logic [NrDoneSrc-1:0]               src_gnt_o,
    output logic                               done_o,
    output logic [IdWidth-1:0]                 done_insn_id_o,
    output logic                               illegal_insn_o,
    output logic [$clog2(MaxInflight+1)-1:0]   inflight_o
);

    localparam int PtrW = $clog2(QueueDepth);
    localparam int CntW = $clog2(QueueDepth + 1);
    localparam int InfW = $clog2(MaxInflight + 1);

    frontend_entry_t mem_q [QueueDepth];
    frontend_entry_t entry_in, head;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [InfW-1:0] inflight_q, inflight_d;
    logic            full, empty, push, pop;

    // ---- Issue side: FIFO with fall-through head ----
    assign full  = (count_q == CntW'(QueueDepth));
    assign empty = (count_q == '0);

    // Credit check counts queued entries too, so a full credit pool blocks
    // issue even when the FIFO itself has room.
    assign ready_o     = !full && !flush_i &&
                         ((int'(count_q) + int'(inflight_q)) < MaxInflight);
    assign dec_valid_o = !empty && !flush_i;
    assign push        = valid_i && ready_o;
    assign pop         = dec_valid_o && dec_ready_i;

    always_comb begin
        entry_in.insn   = insn_i;
        entry_in.id     = insn_id_t'(insn_id_i);
        entry_in.scalar = scalar_reg_i;
        entry_in.ctx    = vec_context_t'(vec_context_i);
    end

    assign head         = mem_q[rptr_q];
    assign dec_insn_o   = head.insn;
    assign dec_id_o     = IdWidth'(head.id);
    assign dec_scalar_o = head.scalar;
    assign dec_ctx_o    = head.ctx;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= entry_in;
        end
    end

    // ---- Completion side: round-robin merge of done sources ----
    logic                 gnt_valid, gnt_ill;
    logic [IdWidth-1:0]   gnt_id;
    logic                 done_q, illegal_q;
    logic [IdWidth-1:0]   done_id_q;

    rvv_issue_frontend_rr_arbiter #(
        .NrReq (NrDoneSrc)
    ) i_done_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (src_done_i),
        .advance_i (1'b1),
        .gnt_o     (src_gnt_o)
    );

    assign gnt_valid = |src_gnt_o;

    always_comb begin
        gnt_id  = '0;
        gnt_ill = 1'b0;
        for (int s = 0; s < NrDoneSrc; s++) begin
            if (src_gnt_o[s]) begin
                gnt_id  = gnt_id | src_done_id_i[s*IdWidth +: IdWidth];
                gnt_ill = gnt_ill | src_illegal_i[s];
            end
        end
    end

    // Pop adds a credit, grant returns one; an underflowing grant is clamped.
    always_comb begin
        inflight_d = inflight_q;
        case ({pop, gnt_valid})
            2'b10:   inflight_d = inflight_q + InfW'(1);
            2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - InfW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            done_id_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            done_q     <= gnt_valid;
            illegal_q  <= gnt_valid && gnt_ill;
            if (gnt_valid) begin
                done_id_q <= gnt_id;
            end
        end
    end

    assign done_o         = done_q;
    assign illegal_insn_o = illegal_q;
    assign done_insn_id_o = done_id_q;
    assign inflight_o     = inflight_q;

    // A completion with nothing dispatched means a source reported a bogus ID.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(gnt_valid && !pop && (inflight_q == '0)));

endmodule

// File: tb/tb_rvv_issue_frontend.sv
// -----------------------------------------------------------------------------
// tb_rvv_issue_frontend
// Directed bench for rvv_issue_frontend with default parameters
// (4-entry queue, 3 done sources, 8 credits, 3-bit IDs).
// -----------------------------------------------------------------------------
module tb_rvv_issue_frontend;
    import rvv_issue_frontend_pkg::*;

    localparam int IdW = 3;
    localparam int NS  = 3;
    localparam int CtxW = $bits(vec_context_t);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       insn_i;
    logic [IdW-1:0]    insn_id_i;
    logic [XLEN-1:0]   scalar_reg_i;
    logic [CtxW-1:0]   vec_context_i;
    logic              flush_i;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [31:0]       dec_insn_o;
    logic [IdW-1:0]    dec_id_o;
    logic [XLEN-1:0]   dec_scalar_o;
    logic [CtxW-1:0]   dec_ctx_o;
    logic [NS-1:0]     src_done_i;
    logic [NS*IdW-1:0] src_done_id_i;
    logic [NS-1:0]     src_illegal_i;
    logic [NS-1:0]     src_gnt_o;
    logic              done_o;
    logic [IdW-1:0]    done_insn_id_o;
    logic              illegal_insn_o;
    logic [3:0]        inflight_o;

    int tests  = 0;
    int failed = 0;

    rvv_issue_frontend dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .insn_i         (insn_i),
        .insn_id_i      (insn_id_i),
        .scalar_reg_i   (scalar_reg_i),
        .vec_context_i  (vec_context_i),
        .flush_i        (flush_i),
        .dec_valid_o    (dec_valid_o),
        .dec_ready_i    (dec_ready_i),
        .dec_insn_o     (dec_insn_o),
        .dec_id_o       (dec_id_o),
        .dec_scalar_o   (dec_scalar_o),
        .dec_ctx_o      (dec_ctx_o),
        .src_done_i     (src_done_i),
        .src_done_id_i  (src_done_id_i),
        .src_illegal_i  (src_illegal_i),
        .src_gnt_o      (src_gnt_o),
        .done_o         (done_o),
        .done_insn_id_o (done_insn_id_o),
        .illegal_insn_o (illegal_insn_o),
        .inflight_o     (inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input int id, input logic [31:0] insn);
        valid_i       = v;
        insn_id_i     = IdW'(id);
        insn_i        = insn;
        scalar_reg_i  = insn ^ 32'hA5A5_0000;
        vec_context_i = CtxW'(insn[7:0]) + CtxW'(24'h010100);
    endtask

    initial begin
        rst_i         = 1'b1;
        valid_i       = 1'b0;
        insn_i        = '0;
        insn_id_i     = '0;
        scalar_reg_i  = '0;
        vec_context_i = '0;
        flush_i       = 1'b0;
        dec_ready_i   = 1'b0;
        src_done_i    = '0;
        src_done_id_i = '0;
        src_illegal_i = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_dec_valid", 64'(dec_valid_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_illegal", 64'(illegal_insn_o), 64'd0);
        chk("rst_done_id", 64'(done_insn_id_o), 64'd0);
        chk("rst_inflight", 64'(inflight_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);

        // Fill the queue with the decoder stalled
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 32'h1000 + i);
            #1;
            chk("fill_ready", 64'(ready_o), 64'd1);
            tick();
            chk("fill_dec_valid", 64'(dec_valid_o), 64'd1);
        end
        drive(1'b0, 0, 32'h0);
        #1;
        chk("full_ready", 64'(ready_o), 64'd0);
        chk("full_head_id", 64'(dec_id_o), 64'd0);

        // Drain in order
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 64'(dec_valid_o), 64'd1);
            chk("drain_id", 64'(dec_id_o), 64'(i));
            chk("drain_insn", 64'(dec_insn_o), 64'(32'h1000 + i));
            chk("drain_scalar", 64'(dec_scalar_o), 64'((32'h1000 + i) ^ 32'hA5A5_0000));
            chk("drain_ctx", 64'(dec_ctx_o), 64'(24'h010100 + i));
            tick();
        end
        dec_ready_i = 1'b0;
        #1;
        chk("drained_valid", 64'(dec_valid_o), 64'd0);
        chk("drained_inflight", 64'(inflight_o), 64'd4);
        chk("drained_ready", 64'(ready_o), 64'd1);

        // Dispatch four more straight through: credit pool exhausted
        dec_ready_i = 1'b1;
        for (int i = 4; i < 8; i++) begin
            drive(1'b1, i, 32'h1000 + i);
            #1;
            chk("credit_ready", 64'(ready_o), 64'd1);
            tick();
        end
        drive(1'b0, 0, 32'h0);
        tick();
        dec_ready_i = 1'b0;
        #1;
        chk("credit_inflight", 64'(inflight_o), 64'd8);
        chk("credit_ready_low", 64'(ready_o), 64'd0);
        chk("credit_empty", 64'(dec_valid_o), 64'd0);

        // One completion from source 2 returns a credit
        src_done_i = 3'b100;
        src_done_id_i[8:6] = 3'd0;
        #1;
        chk("single_gnt", 64'(src_gnt_o), 64'b100);
        tick();
        src_done_i = '0;
        chk("single_done", 64'(done_o), 64'd1);
        chk("single_id", 64'(done_insn_id_o), 64'd0);
        chk("single_inflight", 64'(inflight_o), 64'd7);
        #1;
        chk("single_ready", 64'(ready_o), 64'd1);
        tick();
        chk("single_done_off", 64'(done_o), 64'd0);

        // All three sources held: rotate 0,1,2
        src_done_id_i = {3'd7, 3'd6, 3'd5};
        src_done_i = 3'b111;
        #1;
        chk("rr_gnt0", 64'(src_gnt_o), 64'b001);
        tick();
        chk("rr_done0", 64'(done_o), 64'd1);
        chk("rr_id0", 64'(done_insn_id_o), 64'd5);
        #1;
        chk("rr_gnt1", 64'(src_gnt_o), 64'b010);
        tick();
        chk("rr_done1", 64'(done_o), 64'd1);
        chk("rr_id1", 64'(done_insn_id_o), 64'd6);
        #1;
        chk("rr_gnt2", 64'(src_gnt_o), 64'b100);
        tick();
        chk("rr_done2", 64'(done_o), 64'd1);
        chk("rr_id2", 64'(done_insn_id_o), 64'd7);
        src_done_i = '0;
        tick();
        chk("rr_done_off", 64'(done_o), 64'd0);
        chk("rr_id_hold", 64'(done_insn_id_o), 64'd7);
        chk("rr_inflight", 64'(inflight_o), 64'd4);

        // Sources 0 and 2 held: pointer forces 0 then 2
        src_done_id_i = {3'd3, 3'd0, 3'd1};
        src_done_i = 3'b101;
        #1;
        chk("rr101_gnt0", 64'(src_gnt_o), 64'b001);
        tick();
        chk("rr101_id0", 64'(done_insn_id_o), 64'd1);
        #1;
        chk("rr101_gnt1", 64'(src_gnt_o), 64'b100);
        tick();
        chk("rr101_id1", 64'(done_insn_id_o), 64'd3);
        src_done_i = '0;
        tick();
        chk("rr101_inflight", 64'(inflight_o), 64'd2);

        // Illegal completion from source 1
        src_done_i = 3'b010;
        src_done_id_i[5:3] = 3'd2;
        src_illegal_i = 3'b010;
        #1;
        chk("ill_gnt", 64'(src_gnt_o), 64'b010);
        chk("ill_early", 64'(illegal_insn_o), 64'd0);
        tick();
        src_done_i = '0;
        src_illegal_i = '0;
        chk("ill_done", 64'(done_o), 64'd1);
        chk("ill_flag", 64'(illegal_insn_o), 64'd1);
        chk("ill_id", 64'(done_insn_id_o), 64'd2);
        tick();
        chk("ill_done_off", 64'(done_o), 64'd0);
        chk("ill_flag_off", 64'(illegal_insn_o), 64'd0);
        chk("ill_id_hold", 64'(done_insn_id_o), 64'd2);
        chk("ill_inflight", 64'(inflight_o), 64'd1);

        // Queue three, then flush while offering another
        dec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 32'h2000 + i);
            tick();
        end
        drive(1'b1, 7, 32'h2007);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 64'(ready_o), 64'd0);
        chk("flush_dec_valid", 64'(dec_valid_o), 64'd0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 0, 32'h0);
        #1;
        chk("post_flush_valid", 64'(dec_valid_o), 64'd0);
        chk("post_flush_ready", 64'(ready_o), 64'd1);
        chk("post_flush_inflight", 64'(inflight_o), 64'd1);
        dec_ready_i = 1'b1;
        tick();
        dec_ready_i = 1'b0;
        chk("post_flush_nopop", 64'(inflight_o), 64'd1);

        // Queue realigned after flush
        drive(1'b1, 3, 32'h2003);
        tick();
        drive(1'b0, 0, 32'h0);
        #1;
        chk("realign_valid", 64'(dec_valid_o), 64'd1);
        chk("realign_id", 64'(dec_id_o), 64'd3);
        chk("realign_insn", 64'(dec_insn_o), 64'h2003);
        dec_ready_i = 1'b1;
        tick();
        dec_ready_i = 1'b0;
        chk("realign_inflight", 64'(inflight_o), 64'd2);

        // Earlier dispatch still completes; pointer at 2 wraps to source 0
        src_done_i = 3'b001;
        src_done_id_i[2:0] = 3'd4;
        #1;
        chk("wrap_gnt", 64'(src_gnt_o), 64'b001);
        tick();
        src_done_i = '0;
        chk("wrap_done", 64'(done_o), 64'd1);
        chk("wrap_id", 64'(done_insn_id_o), 64'd4);
        chk("wrap_inflight", 64'(inflight_o), 64'd1);

        // Build up count 2, inflight 3, then reset mid-cycle
        dec_ready_i = 1'b1;
        drive(1'b1, 5, 32'h3005);
        tick();
        drive(1'b1, 6, 32'h3006);
        tick();
        drive(1'b0, 0, 32'h0);
        tick();
        dec_ready_i = 1'b0;
        drive(1'b1, 0, 32'h3000);
        tick();
        drive(1'b1, 1, 32'h3001);
        tick();
        drive(1'b0, 0, 32'h0);
        #1;
        chk("pre_rst_inflight", 64'(inflight_o), 64'd3);
        chk("pre_rst_valid", 64'(dec_valid_o), 64'd1);
        chk("pre_rst_id", 64'(dec_id_o), 64'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 64'(dec_valid_o), 64'd0);
        chk("async_rst_inflight", 64'(inflight_o), 64'd0);
        chk("async_rst_done", 64'(done_o), 64'd0);
        chk("async_rst_id", 64'(done_insn_id_o), 64'd0);
        chk("async_rst_illegal", 64'(illegal_insn_o), 64'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'd1);
        chk("post_rst_valid", 64'(dec_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
